// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_pkg
// Description : Shared AHB encodings for the bus arbiter: HTRANS and HBURST
//               values, the parked/default master index and the helper that
//               turns a burst type into the beat-counter load value.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    // Master that owns the bus when nobody is requesting.
    localparam int DEFAULT_MASTER = 0;

    // Width of the beat counter (longest fixed burst is 16 beats).
    localparam int CNT_W = 4;

    // Beats remaining after the first beat of a burst. SINGLE and INCR
    // load zero: SINGLE ends on its own beat, INCR only ends on IDLE.
    function automatic logic [CNT_W-1:0] burst_beats_m1(input logic [2:0] hburst);
        logic [CNT_W-1:0] beats;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
            default:                      beats = 4'd0;
        endcase
        return beats;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_pick
// Description : Combinational round-robin picker. Scans the request vector
//               starting at start_i, wrapping modulo N, and returns the first
//               requester found as a one-hot vector.
// Ports       : req_i   [N-1:0] request vector
//               start_i [W-1:0] index where the scan begins (must be < N)
//               gnt_o   [N-1:0] one-hot winner (all zero when no request)
//               valid_o         at least one request was found
// Revision    : 1.0  initial release
// ============================================================================
module rr_priority_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    output logic [N-1:0] gnt_o,
    output logic         valid_o
);

    // One extra bit so start + offset never overflows before the wrap.
    logic [W:0] w_pos;

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        w_pos   = '0;
        for (int i = 0; i < N; i++) begin
            w_pos = {1'b0, start_i} + (W+1)'(i);
            // Explicit wrap rather than a modulo so non-power-of-two N works.
            if (w_pos >= (W+1)'(N)) begin
                w_pos = w_pos - (W+1)'(N);
            end
            if (!valid_o && req_i[w_pos[W-1:0]]) begin
                gnt_o[w_pos[W-1:0]] = 1'b1;
                valid_o             = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahb_bus_arbiter
// Description : Round-robin AHB arbiter for NM (2..16) masters. Re-arbitrates
//               only on transfer boundaries (IDLE, SINGLE NONSEQ, last SEQ
//               of a fixed-length burst) and never while the current owner
//               holds HLOCK. Produces the registered grant plus the
//               address-phase and data-phase owner indices.
// Ports       : HCLK            bus clock, rising edge
//               HRESETn         asynchronous active-low reset
//               HBUSREQ [NM-1:0] per-master request
//               HLOCK   [NM-1:0] per-master lock request
//               HTRANS  [1:0]   transfer type of the current owner
//               HBURST  [2:0]   burst type of the current owner
//               HREADY          bus-wide ready
//               HGRANT  [NM-1:0] one-hot grant (registered)
//               HMASTER [MW-1:0] address-phase owner
//               HMASTER_D [MW-1:0] data-phase owner
//               HMASTLOCK       current address phase is locked
// Revision    : 1.0  initial release
// ============================================================================
module ahb_bus_arbiter #(
    parameter int NM = 4,
    parameter int MW = $clog2(NM)
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [NM-1:0] HBUSREQ,
    input  logic [NM-1:0] HLOCK,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HBURST,
    input  logic          HREADY,
    output logic [NM-1:0] HGRANT,
    output logic [MW-1:0] HMASTER,
    output logic [MW-1:0] HMASTER_D,
    output logic          HMASTLOCK
);

    import ahb_pkg::*;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NM-1:0]    grant_q,  grant_d;
    logic [MW-1:0]    aowner_q, aowner_d;   // address-phase owner
    logic [MW-1:0]    downer_q, downer_d;   // data-phase owner
    logic             mlock_q,  mlock_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;      // beats left in a fixed burst
    logic [MW-1:0]    last_q,   last_d;     // last real winner

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [MW-1:0] w_owner;      // index of the current grant
    logic [MW-1:0] w_start;      // round-robin scan origin
    logic [NM-1:0] w_win_gnt;
    logic          w_win_valid;
    logic [MW-1:0] w_win_idx;
    logic          w_lock_held;
    logic          w_bnd;

    // One-hot to index conversion for both the grant and the winner.
    always_comb begin
        w_owner   = '0;
        w_win_idx = '0;
        for (int i = 0; i < NM; i++) begin
            if (grant_q[i]) begin
                w_owner = w_owner | MW'(i);
            end
            if (w_win_gnt[i]) begin
                w_win_idx = w_win_idx | MW'(i);
            end
        end
    end

    // Scan begins one past the last winner so every requester gets a turn.
    assign w_start = (last_q == MW'(NM-1)) ? '0 : last_q + MW'(1);

    rr_priority_pick #(
        .N (NM),
        .W (MW)
    ) u_pick (
        .req_i   (HBUSREQ),
        .start_i (w_start),
        .gnt_o   (w_win_gnt),
        .valid_o (w_win_valid)
    );

    assign w_lock_held = HLOCK[w_owner];

    // A transfer boundary: the owner may be switched at the next edge.
    // INCR NONSEQ/SEQ never qualify because cnt stays at zero for INCR.
    always_comb begin
        w_bnd = 1'b0;
        if (HREADY) begin
            case (HTRANS)
                HTRANS_IDLE:   w_bnd = 1'b1;
                HTRANS_NONSEQ: w_bnd = (HBURST == HBURST_SINGLE);
                HTRANS_SEQ:    w_bnd = (cnt_q == 4'd1);
                default:       w_bnd = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; everything holds while HREADY is low.
    // ------------------------------------------------------------------
    always_comb begin
        grant_d  = grant_q;
        aowner_d = aowner_q;
        downer_d = downer_q;
        mlock_d  = mlock_q;
        cnt_d    = cnt_q;
        last_d   = last_q;

        if (HREADY) begin
            aowner_d = w_owner;
            downer_d = aowner_q;
            mlock_d  = HLOCK[w_owner];

            case (HTRANS)
                // NONSEQ also covers early termination: always reload.
                HTRANS_NONSEQ: cnt_d = burst_beats_m1(HBURST);
                HTRANS_SEQ: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: cnt_d = cnt_q;
            endcase

            if (w_bnd && !w_lock_held) begin
                if (w_win_valid) begin
                    grant_d = w_win_gnt;
                    last_d  = w_win_idx;
                end else begin
                    // Park without touching the rotation pointer.
                    grant_d                 = '0;
                    grant_d[DEFAULT_MASTER] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q                 <= '0;
            grant_q[DEFAULT_MASTER] <= 1'b1;
            aowner_q                <= '0;
            downer_q                <= '0;
            mlock_q                 <= 1'b0;
            cnt_q                   <= '0;
            last_q                  <= '0;
        end else begin
            grant_q  <= grant_d;
            aowner_q <= aowner_d;
            downer_q <= downer_d;
            mlock_q  <= mlock_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = aowner_q;
    assign HMASTER_D = downer_q;
    assign HMASTLOCK = mlock_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_bus_arbiter
// Description : Self-checking bench for ahb_bus_arbiter (NM = 4). Directed
//               vector table, multi-cycle corner sequences and a randomized
//               run against a behavioural model of the arbitration rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_bus_arbiter;

    localparam int NM = 4;
    localparam int MW = 2;

    logic          HCLK    = 1'b0;
    logic          HRESETn = 1'b0;
    logic [NM-1:0] HBUSREQ = '0;
    logic [NM-1:0] HLOCK   = '0;
    logic [1:0]    HTRANS  = 2'd0;
    logic [2:0]    HBURST  = 3'd0;
    logic          HREADY  = 1'b1;
    logic [NM-1:0] HGRANT;
    logic [MW-1:0] HMASTER;
    logic [MW-1:0] HMASTER_D;
    logic          HMASTLOCK;

    ahb_bus_arbiter #(.NM(NM)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTER_D (HMASTER_D),
        .HMASTLOCK (HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state (plain integers).
    int m_own, m_hm, m_hmd, m_ml, m_cnt, m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int beats_m1(input int b);
        return (b >= 2) ? ((4 << ((b - 2) / 2)) - 1) : 0;
    endfunction

    task automatic model_reset();
        m_own = 0; m_hm = 0; m_hmd = 0; m_ml = 0; m_cnt = 0; m_last = 0;
    endtask

    task automatic model_step(input logic [NM-1:0] req, input logic [NM-1:0] lock,
                              input int tr, input int bu, input logic rdy);
        int  ng, nl;
        bit  bnd, found;
        if (!rdy) return;
        bnd = (tr == 0) || (tr == 2 && bu == 0) || (tr == 3 && m_cnt == 1);
        ng  = m_own;
        nl  = m_last;
        if (bnd && !lock[m_own]) begin
            found = 0;
            ng    = 0;
            for (int k = 1; k <= NM; k++) begin
                int m;
                m = (m_last + k) % NM;
                if (!found && req[m]) begin
                    ng = m; nl = m; found = 1;
                end
            end
        end
        m_hmd  = m_hm;
        m_hm   = m_own;
        m_ml   = lock[m_own] ? 1 : 0;
        m_own  = ng;
        m_last = nl;
        if (tr == 2)                    m_cnt = beats_m1(bu);
        else if (tr == 3 && m_cnt > 0)  m_cnt = m_cnt - 1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_grant"},     32'(HGRANT),    32'(1 << m_own));
        chk({tag, "_hmaster"},   32'(HMASTER),   32'(m_hm));
        chk({tag, "_hmaster_d"}, 32'(HMASTER_D), 32'(m_hmd));
        chk({tag, "_hmastlock"}, 32'(HMASTLOCK), 32'(m_ml));
    endtask

    // Drive one cycle of inputs, advance the model, then sample after the edge.
    task automatic cyc(input logic [NM-1:0] req, input logic [NM-1:0] lock,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
        HBUSREQ = req; HLOCK = lock; HTRANS = tr; HBURST = bu; HREADY = rdy;
        model_step(req, lock, int'(tr), int'(bu), rdy);
        @(posedge HCLK);
        #1;
        check_model("mdl");
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        HBUSREQ = '0; HLOCK = '0; HTRANS = 2'd0; HBURST = 3'd0; HREADY = 1'b1;
        model_reset();
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        chk("rst_grant",     32'(HGRANT),    32'h1);
        chk("rst_hmaster",   32'(HMASTER),   32'h0);
        chk("rst_hmaster_d", 32'(HMASTER_D), 32'h0);
        chk("rst_hmastlock", 32'(HMASTLOCK), 32'h0);
    endtask

    typedef struct {
        logic [3:0] req;
        logic [1:0] tr;
        logic [2:0] bu;
        logic       rdy;
        logic [3:0] g;
        int         hm;
        int         hmd;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // Expected values derived by hand from the arbitration rules.
        tbl[0]  = '{4'b0110, 2'd0, 3'd0, 1'b1, 4'b0010, 0, 0};
        tbl[1]  = '{4'b0110, 2'd0, 3'd0, 1'b1, 4'b0100, 1, 0};
        tbl[2]  = '{4'b1111, 2'd0, 3'd0, 1'b1, 4'b1000, 2, 1};
        tbl[3]  = '{4'b1111, 2'd0, 3'd0, 1'b1, 4'b0001, 3, 2};
        tbl[4]  = '{4'b1111, 2'd0, 3'd0, 1'b1, 4'b0010, 0, 3};
        tbl[5]  = '{4'b0000, 2'd0, 3'd0, 1'b1, 4'b0001, 1, 0};
        tbl[6]  = '{4'b0000, 2'd0, 3'd0, 1'b0, 4'b0001, 1, 0};
        tbl[7]  = '{4'b0100, 2'd0, 3'd0, 1'b0, 4'b0001, 1, 0};
        tbl[8]  = '{4'b0100, 2'd0, 3'd0, 1'b1, 4'b0100, 0, 1};
        tbl[9]  = '{4'b0100, 2'd0, 3'd0, 1'b1, 4'b0100, 2, 0};
        tbl[10] = '{4'b0010, 2'd2, 3'd1, 1'b1, 4'b0100, 2, 2};
        tbl[11] = '{4'b0010, 2'd3, 3'd1, 1'b1, 4'b0100, 2, 2};
        tbl[12] = '{4'b0010, 2'd0, 3'd1, 1'b1, 4'b0010, 2, 2};

        // ---------------- directed vector table ----------------
        do_reset();
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].req, 4'b0000, tbl[i].tr, tbl[i].bu, tbl[i].rdy);
            chk($sformatf("vec%0d_grant", i),     32'(HGRANT),    32'(tbl[i].g));
            chk($sformatf("vec%0d_hmaster", i),   32'(HMASTER),   32'(tbl[i].hm));
            chk($sformatf("vec%0d_hmaster_d", i), 32'(HMASTER_D), 32'(tbl[i].hmd));
            chk($sformatf("vec%0d_hmastlock", i), 32'(HMASTLOCK), 32'h0);
        end

        // ---------------- INCR4 handover at the last beat ----------------
        do_reset();
        cyc(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1);
        chk("incr4_own", 32'(HGRANT), 32'h2);
        cyc(4'b0110, 4'b0000, 2'd2, 3'd3, 1'b1);
        chk("incr4_b1", 32'(HGRANT), 32'h2);
        cyc(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1);
        chk("incr4_b2", 32'(HGRANT), 32'h2);
        cyc(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1);
        chk("incr4_b3", 32'(HGRANT), 32'h2);
        cyc(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1);
        chk("incr4_handover", 32'(HGRANT), 32'h4);

        // ---------------- INCR4 with a 3-cycle stall on beat 2 ----------------
        do_reset();
        cyc(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1);
        cyc(4'b0110, 4'b0000, 2'd2, 3'd3, 1'b1);
        for (int s = 0; s < 3; s++) begin
            cyc(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b0);
            chk("stall_grant",   32'(HGRANT),  32'h2);
            chk("stall_hmaster", 32'(HMASTER), 32'h1);
        end
        cyc(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1);
        chk("stall_b2", 32'(HGRANT), 32'h2);
        cyc(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1);
        chk("stall_b3", 32'(HGRANT), 32'h2);
        cyc(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1);
        chk("stall_handover", 32'(HGRANT), 32'h4);

        // ---------------- locked SINGLE transfers from master 3 ----------------
        do_reset();
        cyc(4'b1000, 4'b0000, 2'd0, 3'd0, 1'b1);
        chk("lock_own", 32'(HGRANT), 32'h8);
        cyc(4'b1001, 4'b1000, 2'd2, 3'd0, 1'b1);
        chk("lock_s1_grant", 32'(HGRANT),    32'h8);
        chk("lock_s1_ml",    32'(HMASTLOCK), 32'h1);
        cyc(4'b1001, 4'b1000, 2'd2, 3'd0, 1'b1);
        chk("lock_s2_grant", 32'(HGRANT),    32'h8);
        chk("lock_s2_ml",    32'(HMASTLOCK), 32'h1);
        chk("lock_s2_hm",    32'(HMASTER),   32'h3);
        cyc(4'b1001, 4'b0000, 2'd0, 3'd0, 1'b1);
        chk("lock_release_grant", 32'(HGRANT),    32'h1);
        chk("lock_release_ml",    32'(HMASTLOCK), 32'h0);

        // ---------------- asynchronous reset during WRAP8 beat 5 ----------------
        do_reset();
        cyc(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1);
        cyc(4'b0010, 4'b0010, 2'd2, 3'd4, 1'b1);
        for (int b = 0; b < 3; b++) begin
            cyc(4'b0010, 4'b0010, 2'd3, 3'd4, 1'b1);
        end
        HTRANS = 2'd3;
        #3;
        HRESETn = 1'b0;
        #1;
        chk("arst_grant",     32'(HGRANT),    32'h1);
        chk("arst_hmaster",   32'(HMASTER),   32'h0);
        chk("arst_hmaster_d", 32'(HMASTER_D), 32'h0);
        chk("arst_hmastlock", 32'(HMASTLOCK), 32'h0);
        model_reset();
        HBUSREQ = '0; HLOCK = '0; HTRANS = 2'd0; HBURST = 3'd0;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        cyc(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1);
        chk("arst_after_grant", 32'(HGRANT), 32'h2);

        // ---------------- randomized run against the model ----------------
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cyc(4'($urandom), 4'($urandom & $urandom), 2'($urandom_range(0, 3)),
                3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
